// File: rtl/fft_peak_detect.sv
// Spectrum peak/energy monitor for a 32-point streaming FFT.
// Captures one frame per res_ready rising edge and reports the strongest bin and the total |X|^2.
module fft_peak_detect #(
  parameter int N    = 32,
  parameter int LOGN = 5,
  parameter int W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_ready,
  input  logic signed [W-1:0]   data_o_r,
  input  logic signed [W-1:0]   data_o_i,
  output logic                  busy,
  output logic                  done,
  output logic [LOGN-1:0]       peak_idx,
  output logic [2*W-1:0]        peak_mag,
  output logic [2*W+LOGN-1:0]   energy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_rr;
  logic [LOGN-1:0]           r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_overrun;
  logic [LOGN-1:0]           r_peak_idx;
  logic [2*W-1:0]            r_peak_mag;
  logic [2*W+LOGN-1:0]       r_energy;

  logic                      r_v1, r_first1, r_last1;
  logic [LOGN-1:0]           r_idx1;
  logic signed [W-1:0]       r_re1, r_im1;
  logic                      r_v2, r_first2, r_last2;
  logic [LOGN-1:0]           r_idx2;
  logic signed [2*W-1:0]     r_pre2, r_pim2;
  logic                      r_last3;
  logic [2*W+LOGN-1:0]       r_acc;
  logic [2*W-1:0]            r_max;
  logic [LOGN-1:0]           r_maxidx;

  logic                      w_start;
  logic                      w_fin;
  logic signed [2*W-1:0]     w_re_x, w_im_x;
  logic [2*W-1:0]            w_mag;

  assign w_start = res_ready & ~r_rr;
  assign w_fin   = (r_state == ST_DRAIN) & r_last3;
  assign w_re_x  = {{W{r_re1[W-1]}}, r_re1};
  assign w_im_x  = {{W{r_im1[W-1]}}, r_im1};
  // Both squares are at most 2^(2W-2), so their unsigned sum fits 2W bits exactly.
  assign w_mag   = $unsigned(r_pre2) + $unsigned(r_pim2);

  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_overrun;
  assign peak_idx = r_peak_idx;
  assign peak_mag = r_peak_mag;
  assign energy   = r_energy;

  // State register, edge detector and bin counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_rr    <= res_ready;
      if (r_state == ST_CAPTURE) begin
        r_cnt <= r_cnt + LOGN'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_CAPTURE;
        else         w_next = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (r_cnt == LAST) w_next = ST_DRAIN;
        else               w_next = ST_CAPTURE;
      end
      ST_DRAIN: begin
        if (r_last3) w_next = ST_IDLE;
        else         w_next = ST_DRAIN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Three-stage magnitude pipeline: sample, square, accumulate/compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0; r_first1 <= 1'b0; r_last1 <= 1'b0; r_idx1 <= '0;
      r_re1 <= '0;  r_im1 <= '0;
      r_v2 <= 1'b0; r_first2 <= 1'b0; r_last2 <= 1'b0; r_idx2 <= '0;
      r_pre2 <= '0; r_pim2 <= '0;
      r_last3 <= 1'b0; r_acc <= '0; r_max <= '0; r_maxidx <= '0;
    end else begin
      r_v1     <= (r_state == ST_CAPTURE);
      r_first1 <= (r_cnt == '0);
      r_last1  <= (r_cnt == LAST);
      r_idx1   <= r_cnt;
      r_re1    <= data_o_r;
      r_im1    <= data_o_i;
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_idx2   <= r_idx1;
      r_pre2   <= w_re_x * w_re_x;
      r_pim2   <= w_im_x * w_im_x;
      r_last3  <= r_v2 & r_last2;
      if (r_v2 && r_first2) begin
        r_acc    <= {{LOGN{1'b0}}, w_mag};
        r_max    <= w_mag;
        r_maxidx <= r_idx2;
      end else if (r_v2) begin
        r_acc <= r_acc + {{LOGN{1'b0}}, w_mag};
        // Strict compare keeps the lowest index on ties.
        if (w_mag > r_max) begin
          r_max    <= w_mag;
          r_maxidx <= r_idx2;
        end else begin
          r_max    <= r_max;
          r_maxidx <= r_maxidx;
        end
      end else begin
        r_acc    <= r_acc;
        r_max    <= r_max;
        r_maxidx <= r_maxidx;
      end
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_peak_idx <= '0;
      r_peak_mag <= '0;
      r_energy   <= '0;
    end else begin
      r_overrun <= w_start & (r_state != ST_IDLE);
      r_done    <= w_fin;
      if (w_fin) begin
        r_busy     <= 1'b0;
        r_peak_idx <= r_maxidx;
        r_peak_mag <= r_max;
        r_energy   <= r_acc;
      end else if (w_start && (r_state == ST_IDLE)) begin
        r_busy <= 1'b1;
      end else begin
        r_busy <= r_busy;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect: hand-computed frames, latency,
// tie-break, extreme values, overrun, back-to-back frames and mid-frame reset.
module tb_fft_peak_detect;

  logic               clk;
  logic               reset;
  logic               res_ready;
  logic signed [15:0] data_o_r;
  logic signed [15:0] data_o_i;
  logic               busy;
  logic               done;
  logic [4:0]         peak_idx;
  logic [31:0]        peak_mag;
  logic [36:0]        energy;
  logic               overrun;

  logic signed [15:0] bre [32];
  logic signed [15:0] bim [32];

  int checks   = 0;
  int failures = 0;

  fft_peak_detect #(.N(32), .LOGN(5), .W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .res_ready (res_ready),
    .data_o_r  (data_o_r),
    .data_o_i  (data_o_i),
    .busy      (busy),
    .done      (done),
    .peak_idx  (peak_idx),
    .peak_mag  (peak_mag),
    .energy    (energy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_bins();
    for (int i = 0; i < 32; i++) begin
      bre[i] = 16'sd0;
      bim[i] = 16'sd0;
    end
  endtask

  // Called at a negedge with res_ready low; returns at the negedge where done is seen.
  task automatic run_frame(input string tag, input bit inj_ovr, input int exp_ovr,
                           input logic [4:0] e_idx, input logic [31:0] e_mag,
                           input logic [36:0] e_en);
    int n;
    int ovr;
    bit early;
    n = 0; ovr = 0; early = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      n++;
      if (k == 0) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) early = 1'b1;
      if (overrun) ovr++;
      data_o_r = bre[k];
      data_o_i = bim[k];
      if (inj_ovr && k == 10) res_ready = 1'b0;
      if (inj_ovr && k == 11) res_ready = 1'b1;
    end
    res_ready = 1'b0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
      if (overrun) ovr++;
      data_o_r = 16'sd0;
      data_o_i = 16'sd0;
    end
    chk({tag, "_latency"}, 64'(n), 64'd36);
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_overrun"}, 64'(ovr), 64'(exp_ovr));
    chk({tag, "_idx"}, 64'(peak_idx), 64'(e_idx));
    chk({tag, "_mag"}, 64'(peak_mag), 64'(e_mag));
    chk({tag, "_energy"}, 64'(energy), 64'(e_en));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dcnt;
    reset     = 1'b0;
    res_ready = 1'b0;
    data_o_r  = 16'sd0;
    data_o_i  = 16'sd0;
    clr_bins();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx", 64'(peak_idx), 64'd0);
    chk("rst_mag", 64'(peak_mag), 64'd0);
    chk("rst_energy", 64'(energy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    clr_bins();
    bre[5] = 16'sd100;
    run_frame("tone", 1'b0, 0, 5'd5, 32'd10000, 37'd10000);
    @(negedge clk);
    chk("tone_done_pulse", 64'(done), 64'd0);
    chk("tone_hold_mag", 64'(peak_mag), 64'd10000);

    clr_bins();
    bim[3] = -16'sd50;
    bre[7] = 16'sd50;
    run_frame("tie", 1'b0, 0, 5'd3, 32'd2500, 37'd5000);
    repeat (2) @(negedge clk);

    clr_bins();
    bre[31] = 16'sh8000;
    bim[31] = 16'sh8000;
    bre[0]  = 16'sh7fff;
    run_frame("extreme", 1'b0, 0, 5'd31, 32'h8000_0000, 37'h0_BFFF_0001);
    repeat (2) @(negedge clk);

    clr_bins();
    bre[9] = 16'sd30;
    bim[9] = 16'sd40;
    bre[4] = -16'sd3;
    run_frame("ovrA", 1'b1, 1, 5'd9, 32'd2500, 37'd2509);
    clr_bins();
    bre[2] = -16'sd127;
    bim[2] = 16'sd127;
    run_frame("b2bB", 1'b0, 0, 5'd2, 32'd32258, 37'd32258);
    @(negedge clk);

    clr_bins();
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      data_o_r = (k == 5) ? 16'sd100 : 16'sd0;
    end
    @(negedge clk);
    reset     = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_idx", 64'(peak_idx), 64'd0);
    chk("arst_mag", 64'(peak_mag), 64'd0);
    chk("arst_energy", 64'(energy), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("arst_no_done", 64'(dcnt), 64'd0);

    clr_bins();
    bre[17] = 16'sd7;
    bim[17] = -16'sd24;
    bre[1]  = 16'sd10;
    run_frame("post_rst", 1'b0, 0, 5'd17, 32'd625, 37'd725);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the 32-point streaming FFT `top`.
- Captures one 32-bin output frame after each `res_ready` rising edge and computes |X|^2 for every bin.
- Reports the strongest bin's index and magnitude, plus the total frame energy.
- Feeds the spectrum-monitor / control logic that sits after the FFT.

Parameters:
- N, 32, bins per frame; a power of 2.
- LOGN, 5, log2(N); width of the bin index.
- W, 16, width of each signed real/imaginary input component.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- res_ready  input  1  frame-ready strobe from the FFT; level signal, edge-detected internally.
- data_o_r  input  W  FFT output bin, real part, signed two's complement.
- data_o_i  input  W  FFT output bin, imaginary part, signed two's complement.
- busy  output  1  high from the start edge until `done`.
- done  output  1  one-cycle pulse; result outputs are updated in the same cycle.
- peak_idx  output  LOGN  index of the largest-magnitude bin.
- peak_mag  output  2W  unsigned re^2+im^2 of the peak bin.
- energy  output  2W+LOGN  unsigned sum of re^2+im^2 over all N bins.
- overrun  output  1  one-cycle pulse when a `res_ready` rising edge arrives while busy.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy=0, done=0, overrun=0, peak_idx=0, peak_mag=0, energy=0; all counters and pipeline registers cleared. Reset asserted mid-frame aborts the frame; no `done` is issued for it.
- Edge detect: `res_ready` is registered each cycle. The start edge is the clock edge at which `res_ready`==1 and its registered value==0.
- Bin k (k = 0..N-1) is sampled at rising edge start+1+k, i.e. bins are taken on consecutive cycles with no gaps, bin 0 on the edge immediately after the start edge.
- States:
  - IDLE: on start edge -> CAPTURE, busy=1, bin counter=0.
  - CAPTURE: sample one bin per cycle; the counter wraps from N-1 to 0 and the state moves to DRAIN on the edge that samples bin N-1.
  - DRAIN: wait for the pipeline to flush, then pulse `done`, clear busy, and return to IDLE.
- Pipeline (3 stages):
  - S1 registers the sampled re/im.
  - S2 registers re*re and im*im as signed 2W-bit products.
  - S3 forms mag = re^2+im^2 (unsigned 2W bits; the maximum 2^31 for W=16 fits exactly), adds it to the energy accumulator, and compares it against the running max.
- Latency: `done` is high for exactly the one cycle beginning at rising edge start+N+3. peak_idx, peak_mag and energy update at that same edge and hold until the next `done` or reset.
- Compare rule: strict greater-than, so on equal magnitudes the lowest index wins. The running max and accumulator are initialised from bin 0 (not compared against 0), so an all-zero frame gives peak_idx=0, peak_mag=0, energy=0.
- Overrun: a start edge while busy is ignored (the frame continues unaffected) and `overrun` pulses for one cycle.
- Back-to-back frames: a start edge in IDLE on the same edge `done` is asserted (the DRAIN->IDLE edge) is not possible. A start edge on the cycle after `done` must be accepted.
- No saturation is needed anywhere: all widths are sized for the worst case, so no overflow can occur.

Test Plan:
- Single tone: start edge, bin 5 = (100, 0), all others 0 -> done at start+35, peak_idx=5, peak_mag=10000, energy=10000, overrun never asserted.
- Tie and sign: bin 3 = (0, -50), bin 7 = (50, 0), rest 0 -> peak_idx=3, peak_mag=2500, energy=5000.
- Extreme value: bin 31 = (0x8000, 0x8000), bin 0 = (0x7fff, 0) -> peak_idx=31, peak_mag=0x80000000, energy=0x80000000+0x3fff0001; no wrap in either output.
- Overrun and back-to-back: toggle `res_ready` low/high at bin 10 of frame A -> overrun pulses once and frame A result is unchanged. Start frame B the cycle after frame A's `done` with bin 2 = (-127, 127) only -> second done, peak_idx=2, peak_mag=32258.
- Reset mid-frame: drop reset at bin 20 for 2 cycles, then release -> all outputs 0 and busy=0 immediately (asynchronous), no `done`. A subsequent clean frame reports correctly.
